// File: rtl/instr_fetch_seq.sv
// Instruction fetch/sequencing unit: owns the PC, fetches 16-bit words over a req/ack handshake,
// splits them into decoder fields and applies ldpc/halt. Optional fetch timeout: FETCH_TIMEOUT_EN.
module instr_fetch_seq #(
  parameter int unsigned     PC_W        = 8,
  parameter logic [PC_W-1:0] RESET_PC    = {PC_W{1'b0}},
  parameter int unsigned     TIMEOUT_CYC = 15
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  output logic            imem_req_o,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [15:0]     imem_rdata_i,
  output logic [2:0]      opcode_o,
  output logic [1:0]      rd_o,
  output logic [1:0]      rs_o,
  output logic [1:0]      rt_o,
  output logic [7:0]      imm_o,
  output logic            instr_valid_o,
  input  logic            ldpc_i,
  input  logic            halt_i,
  output logic [PC_W-1:0] pc_o,
  output logic            halted_o,
  output logic            fault_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    EXEC   = 2'd2,
    HALTED = 2'd3
  } state_e;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            req_q, req_d;
  logic            valid_q, valid_d;
  logic            halted_q, halted_d;
  logic            fault_q, fault_d;
  logic [2:0]      opcode_q, opcode_d;
  logic [1:0]      rd_q, rd_d;
  logic [1:0]      rs_q, rs_d;
  logic [1:0]      rt_q, rt_d;
  logic [7:0]      imm_q, imm_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // State register and all registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      opcode_q <= 3'd0;
      rd_q     <= 2'd0;
      rs_q     <= 2'd0;
      rt_q     <= 2'd0;
      imm_q    <= 8'd0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q    <= {CNT_W{1'b0}};
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
      opcode_q <= opcode_d;
      rd_q     <= rd_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      imm_q    <= imm_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  // Next-state and next-output logic; req/valid are computed for the state being entered
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_d    = 1'b0;
    valid_d  = 1'b0;
    halted_d = halted_q;
    fault_d  = fault_q;
    opcode_d = opcode_q;
    rd_d     = rd_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    imm_d    = imm_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = FETCH;
          req_d   = 1'b1;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = {CNT_W{1'b0}};
`endif
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        if (imem_ack_i) begin
          opcode_d = imem_rdata_i[15:13];
          rd_d     = imem_rdata_i[12:11];
          rs_d     = imem_rdata_i[10:9];
          rt_d     = imem_rdata_i[8:7];
          imm_d    = imem_rdata_i[7:0];
          valid_d  = 1'b1;
          state_d  = EXEC;
`ifdef FETCH_TIMEOUT_EN
        end else if (cnt_q == CNT_LAST) begin
          fault_d  = 1'b1;
          halted_d = 1'b1;
          state_d  = HALTED;
        end else begin
          cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          req_d    = 1'b1;
        end
`else
        end else begin
          req_d    = 1'b1;
        end
`endif
      end
      EXEC: begin
        // halt has priority over a simultaneous branch
        if (halt_i) begin
          halted_d = 1'b1;
          state_d  = HALTED;
        end else begin
          if (ldpc_i) begin
            pc_d = imm_q[PC_W-1:0];
          end else begin
            pc_d = pc_q + PC_ONE;
          end
          req_d   = 1'b1;
          state_d = FETCH;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = {CNT_W{1'b0}};
`endif
        end
      end
      HALTED: begin
        halted_d = 1'b1;
        state_d  = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
`ifndef FETCH_TIMEOUT_EN
    fault_d = 1'b0;
`endif
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign instr_valid_o = valid_q;
  assign halted_o      = halted_q;
  assign fault_o       = fault_q;
  assign opcode_o      = opcode_q;
  assign rd_o          = rd_q;
  assign rs_o          = rs_q;
  assign rt_o          = rt_q;
  assign imm_o         = imm_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Self-checking bench for instr_fetch_seq: vector table of fetched words plus hand-written
// sequences for halt, wait states, reset mid-fetch, PC wrap and fetch timeout.
module tb_instr_fetch_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, ack, ldpc, halt;
  logic [15:0] rdata;
  logic       req, valid, halted, fault;
  logic [7:0] addr, pc, imm;
  logic [2:0] opcode;
  logic [1:0] rd, rs, rt;

  logic       rst2, start2, ack2;
  logic [15:0] rdata2;
  logic       req2, valid2, halted2, fault2;
  logic [7:0] addr2, pc2, imm2;
  logic [2:0] opcode2;
  logic [1:0] rd2, rs2, rt2;

  instr_fetch_seq u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack), .imem_rdata_i(rdata),
    .opcode_o(opcode), .rd_o(rd), .rs_o(rs), .rt_o(rt), .imm_o(imm),
    .instr_valid_o(valid), .ldpc_i(ldpc), .halt_i(halt),
    .pc_o(pc), .halted_o(halted), .fault_o(fault)
  );

  instr_fetch_seq #(.RESET_PC(8'hFF)) u_dut_ff (
    .clk_i(clk), .rst_i(rst2), .start_i(start2),
    .imem_req_o(req2), .imem_addr_o(addr2), .imem_ack_i(ack2), .imem_rdata_i(rdata2),
    .opcode_o(opcode2), .rd_o(rd2), .rs_o(rs2), .rt_o(rt2), .imm_o(imm2),
    .instr_valid_o(valid2), .ldpc_i(1'b0), .halt_i(1'b0),
    .pc_o(pc2), .halted_o(halted2), .fault_o(fault2)
  );

  typedef struct {
    logic [15:0] word;
    int          waits;
    logic        ldpc;
    logic        halt;
    logic [7:0]  addr;
  } vec_t;

  typedef struct {
    logic [15:0] word;
    logic [7:0]  addr;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[8];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Scoreboard: each instr_valid strobe must match the oldest acked word
  always @(negedge clk) begin
    if (!rst && valid === 1'b1) begin
      chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        chk("opcode", 32'(opcode), 32'(mon_e.word[15:13]));
        chk("rd", 32'(rd), 32'(mon_e.word[12:11]));
        chk("rs", 32'(rs), 32'(mon_e.word[10:9]));
        chk("rt", 32'(rt), 32'(mon_e.word[8:7]));
        chk("imm", 32'(imm), 32'(mon_e.word[7:0]));
        chk("exec_pc", 32'(pc), 32'(mon_e.addr));
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int n;
    exp_t e;
    n = 0;
    while (req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("no_bubble", 32'(n), 32'd0);
    chk("fetch_addr", 32'(addr), 32'(v.addr));
    for (int w = 0; w < v.waits; w++) begin
      step();
      chk("wait_req", 32'(req), 32'd1);
      chk("wait_addr", 32'(addr), 32'(v.addr));
      chk("wait_valid", 32'(valid), 32'd0);
    end
    ack   = 1'b1;
    rdata = v.word;
    e.word = v.word;
    e.addr = v.addr;
    sb_q.push_back(e);
    step();
    ack   = 1'b0;
    rdata = 16'h5A5A;
    chk("exec_valid", 32'(valid), 32'd1);
    chk("exec_req", 32'(req), 32'd0);
    ldpc = v.ldpc;
    halt = v.halt;
    step();
    ldpc = 1'b0;
    halt = 1'b0;
    chk("valid_pulse", 32'(valid), 32'd0);
    chk("halted_after", 32'(halted), 32'(v.halt));
  endtask

  initial begin
    int n;
    vecs[0] = '{16'h0000, 0, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{16'h0000, 0, 1'b0, 1'b0, 8'h01};
    vecs[2] = '{16'h0000, 0, 1'b0, 1'b0, 8'h02};
    vecs[3] = '{16'hA020, 0, 1'b1, 1'b0, 8'h03};
    vecs[4] = '{16'h1234, 3, 1'b0, 1'b0, 8'h20};
    vecs[5] = '{16'hFFFF, 0, 1'b1, 1'b0, 8'h21};
    vecs[6] = '{16'h0000, 0, 1'b0, 1'b0, 8'hFF};
    vecs[7] = '{16'hC000, 0, 1'b1, 1'b1, 8'h00};

    rst = 1'b1; start = 1'b0; ack = 1'b0; ldpc = 1'b0; halt = 1'b0; rdata = 16'h0000;
    rst2 = 1'b1; start2 = 1'b0; ack2 = 1'b0; rdata2 = 16'h0000;
    step();
    step();
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_fields", 32'({opcode, rd, rs, rt, imm}), 32'd0);
    rst = 1'b0;

    // ack while idle must be ignored
    ack = 1'b1;
    rdata = 16'hFFFF;
    step();
    ack = 1'b0;
    chk("idle_ack_req", 32'(req), 32'd0);
    chk("idle_ack_fields", 32'({opcode, imm}), 32'd0);

    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_req", 32'(req), 32'd1);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);
    chk("halt_pc", 32'(pc), 32'd0);

    for (int i = 0; i < 20; i++) begin
      start = (i % 3 == 0);
      step();
      chk("halted_req", 32'(req), 32'd0);
      chk("halted_hold", 32'(halted), 32'd1);
      chk("halted_valid", 32'(valid), 32'd0);
    end
    start = 1'b0;

    // reset mid-fetch with a coincident ack
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_exit_halt", 32'(halted), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("mf_req", 32'(req), 32'd1);
    step();
    step();
    rst = 1'b1;
    ack = 1'b1;
    rdata = 16'hE5E5;
    step();
    rst = 1'b0;
    ack = 1'b0;
    chk("mf_req_drop", 32'(req), 32'd0);
    chk("mf_pc", 32'(pc), 32'd0);
    chk("mf_fields", 32'({opcode, imm}), 32'd0);
    step();
    chk("mf_idle_req", 32'(req), 32'd0);
    chk("mf_idle_valid", 32'(valid), 32'd0);

    // ack withheld
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (req === 1'b1 && n < 100) begin
      n++;
      step();
    end
`ifdef FETCH_TIMEOUT_EN
    chk("to_cycles", 32'(n), 32'd15);
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_halted", 32'(halted), 32'd1);
    chk("to_req", 32'(req), 32'd0);
`else
    chk("wait_cycles", 32'(n), 32'd100);
    chk("wait_req_hold", 32'(req), 32'd1);
    chk("wait_fault", 32'(fault), 32'd0);
    chk("wait_halted", 32'(halted), 32'd0);
`endif

    // RESET_PC = 0xFF instance: wrap to 0x00
    step();
    chk("ff_rst_pc", 32'(pc2), 32'hFF);
    chk("ff_rst_req", 32'(req2), 32'd0);
    rst2 = 1'b0;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    chk("ff_req", 32'(req2), 32'd1);
    chk("ff_addr", 32'(addr2), 32'hFF);
    ack2 = 1'b1;
    rdata2 = 16'h2000;
    step();
    ack2 = 1'b0;
    chk("ff_valid", 32'(valid2), 32'd1);
    chk("ff_opcode", 32'(opcode2), 32'd1);
    step();
    chk("ff_wrap_req", 32'(req2), 32'd1);
    chk("ff_wrap_addr", 32'(addr2), 32'h00);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
